// File: rtl/secure_buf_pkg.sv
// ---------------------------------------------------------------------------
// secure_buf_pkg
// Shared types and constants for the secure buffer pipe.
//   mode_t    : buffer ordering (FIFO / LIFO)
//   state_t   : top-level control state (IDLE / RUN)
//   MASK_PAIR : two-bit tile replicated across the word to form the default
//               egress whitening mask (2'b10 -> 0xAAAA... for even widths)
// ---------------------------------------------------------------------------
package secure_buf_pkg;

   typedef enum logic {
      MODE_FIFO = 1'b0,
      MODE_LIFO = 1'b1
   } mode_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [1:0] MASK_PAIR = 2'b10;

endpackage

// File: rtl/secure_buf_mem.sv
// ---------------------------------------------------------------------------
// secure_buf_mem
// DEPTH x WIDTH register file: synchronous write, combinational read.
// Storage is deliberately not reset; occupancy is tracked by the owner.
// Ports:
//   clk   in  clock
//   we    in  write enable
//   waddr in  write address
//   wdata in  write data
//   raddr in  read address
//   rdata out read data (combinational from raddr)
// ---------------------------------------------------------------------------
module secure_buf_mem #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_reg [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_reg[waddr] <= wdata;
      end
   end

   assign rdata = mem_reg[raddr];

endmodule

// File: rtl/secure_buffer_pipe.sv
// ---------------------------------------------------------------------------
// secure_buffer_pipe
// Run-time selectable FIFO/LIFO buffer with per-word key XOR plus a fixed
// whitening mask applied as a word moves into a registered valid/ready
// output stage. Sticky overflow and mode-change error flags.
// Ports:
//   clk, srst        clock, synchronous active-high reset
//   mode_i           0 = FIFO, 1 = LIFO (latched only while IDLE)
//   key_i            egress key, sampled when the output register loads
//   wr_en, wr_data   push strobe / data
//   out_valid/ready  output handshake, out_data = stored ^ key ^ MASK
//   count            buffer occupancy (output register not included)
//   empty, full      count == 0 / count == DEPTH
//   low_th, high_th  count <= LOW_TH / count >= HIGH_TH
//   ovf              sticky: push dropped while full
//   mode_err         sticky: mode_i changed while RUN
//   clr_err          clears ovf and mode_err (a same-cycle set wins)
// ---------------------------------------------------------------------------
module secure_buffer_pipe
   import secure_buf_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 16,
   parameter int LOW_TH  = 2,
   parameter int HIGH_TH = 14,
   parameter logic [WIDTH-1:0] MASK = {(WIDTH/2){MASK_PAIR}}
) (
   input  logic                     clk,
   input  logic                     srst,
   input  logic                     mode_i,
   input  logic [WIDTH-1:0]         key_i,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic                     low_th,
   output logic                     high_th,
   output logic                     ovf,
   output logic                     mode_err,
   input  logic                     clr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   state_t           state_reg, state_next;
   mode_t            mode_reg, mode_next;
   logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0]    count_reg, count_next;
   logic             out_valid_reg, out_valid_next;
   logic [WIDTH-1:0] out_data_reg, out_data_next;
   logic             ovf_reg, ovf_next;
   logic             mode_err_reg, mode_err_next;

   logic             pop;
   logic             push;
   logic             is_full;
   logic [AW-1:0]    top_ptr;
   logic [AW-1:0]    head_addr;
   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [WIDTH-1:0] mem_rdata;

   secure_buf_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (wr_data),
      .raddr (head_addr),
      .rdata (mem_rdata)
   );

   // State register
   always_ff @(posedge clk) begin
      if (srst) begin
         state_reg     <= ST_IDLE;
         mode_reg      <= MODE_FIFO;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         ovf_reg       <= 1'b0;
         mode_err_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         mode_reg      <= mode_next;
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         count_reg     <= count_next;
         out_valid_reg <= out_valid_next;
         out_data_reg  <= out_data_next;
         ovf_reg       <= ovf_next;
         mode_err_reg  <= mode_err_next;
      end
   end

   // Next-state and datapath control
   always_comb begin
      state_next     = state_reg;
      mode_next      = mode_reg;
      wr_ptr_next    = wr_ptr_reg;
      rd_ptr_next    = rd_ptr_reg;
      count_next     = count_reg;
      out_valid_next = out_valid_reg;
      out_data_next  = out_data_reg;
      ovf_next       = ovf_reg;
      mode_err_next  = mode_err_reg;

      is_full   = (count_reg == CW'(DEPTH));
      pop       = (count_reg != '0) && (!out_valid_reg || out_ready);
      push      = wr_en && (!is_full || pop);
      top_ptr   = wr_ptr_reg - AW'(1);
      head_addr = (mode_reg == MODE_LIFO) ? top_ptr : rd_ptr_reg;

      // LIFO push+pop reuses the slot just vacated by the popped top word.
      mem_we    = push;
      mem_waddr = ((mode_reg == MODE_LIFO) && pop) ? top_ptr : wr_ptr_reg;

      if (mode_reg == MODE_LIFO) begin
         if (push && !pop) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
         end else if (pop && !push) begin
            wr_ptr_next = wr_ptr_reg - AW'(1);
         end
      end else begin
         if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
         if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
      end

      if (push && !pop) begin
         count_next = count_reg + CW'(1);
      end else if (pop && !push) begin
         count_next = count_reg - CW'(1);
      end

      if (pop) begin
         out_valid_next = 1'b1;
         out_data_next  = mem_rdata ^ key_i ^ MASK;
      end else if (out_valid_reg && out_ready) begin
         out_valid_next = 1'b0;
      end

      if (wr_en && is_full && !pop) begin
         ovf_next = 1'b1;
      end else if (clr_err) begin
         ovf_next = 1'b0;
      end

      if ((state_reg == ST_RUN) && (mode_t'(mode_i) != mode_reg)) begin
         mode_err_next = 1'b1;
      end else if (clr_err) begin
         mode_err_next = 1'b0;
      end

      case (state_reg)
         ST_IDLE: begin
            mode_next = mode_t'(mode_i);
            // LIFO operation leaves rd_ptr stale; resynchronise while the
            // buffer is empty so either mode starts from a coherent state.
            rd_ptr_next = wr_ptr_reg;
            if (push) state_next = ST_RUN;
         end
         ST_RUN: begin
            if ((count_next == '0) && !out_valid_next) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign count     = count_reg;
   assign empty     = (count_reg == '0);
   assign full      = (count_reg == CW'(DEPTH));
   assign low_th    = (count_reg <= CW'(LOW_TH));
   assign high_th   = (count_reg >= CW'(HIGH_TH));
   assign ovf       = ovf_reg;
   assign mode_err  = mode_err_reg;

endmodule

// File: tb/tb_secure_buffer_pipe.sv
// ---------------------------------------------------------------------------
// tb_secure_buffer_pipe
// Directed stimulus with a scoreboard queue of hand-derived egress words;
// a separate negedge monitor pops and compares on every output handshake.
// ---------------------------------------------------------------------------
module tb_secure_buffer_pipe;

   localparam logic [31:0] M = 32'hAAAA_AAAA;

   logic        clk = 1'b0;
   logic        srst;
   logic        mode_i;
   logic [31:0] key_i;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  count;
   logic        empty, full, low_th, high_th, ovf, mode_err;
   logic        clr_err;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   secure_buffer_pipe dut (
      .clk       (clk),
      .srst      (srst),
      .mode_i    (mode_i),
      .key_i     (key_i),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .low_th    (low_th),
      .high_th   (high_th),
      .ovf       (ovf),
      .mode_err  (mode_err),
      .clr_err   (clr_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (!(empty && !out_valid) && n < 200) begin
         step();
         n++;
      end
      checks++;
      if (n >= 200) begin
         errors++;
         $display("FAIL %s: drain timeout count=%0d out_valid=%0b expected idle", name, count, out_valid);
      end
   endtask

   // Scoreboard monitor: every handshake consumes one expected word.
   always @(negedge clk) begin
      if (!srst && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_data: got %h expected no word", out_data);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (out_data !== e) begin
               errors++;
               $display("FAIL out_data: got %h expected %h", out_data, e);
            end else begin
               $display("out word %h ok", out_data);
            end
         end
      end
   end

   initial begin
      srst = 1'b1; mode_i = 1'b0; key_i = '0; wr_en = 1'b0; wr_data = '0;
      out_ready = 1'b0; clr_err = 1'b0;
      step(); step();
      srst = 1'b0;

      // Reset state
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", out_data, 0);
      chk("rst_low_th", 32'(low_th), 1);
      chk("rst_high_th", 32'(high_th), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_mode_err", 32'(mode_err), 0);

      // FIFO streaming, key 0, 2-cycle latency
      out_ready = 1'b1;
      exp_q.push_back(32'h1 ^ M);
      exp_q.push_back(32'h2 ^ M);
      exp_q.push_back(32'h3 ^ M);
      wr_en = 1'b1; wr_data = 32'h1;
      step();
      chk("fifo_cnt_after_push", 32'(count), 1);
      chk("fifo_valid_n", 32'(out_valid), 0);
      wr_data = 32'h2;
      step();
      chk("fifo_valid_n1", 32'(out_valid), 1);
      wr_data = 32'h3;
      step();
      wr_en = 1'b0;
      wait_idle("fifo");
      $display("fifo stream done");

      // LIFO with key, out_ready low during pushes
      mode_i = 1'b1; key_i = 32'hFFFF_0000; out_ready = 1'b0;
      step();
      push(32'h1111_2222);
      push(32'h3333_4444);
      push(32'h5555_6666);
      chk("lifo_count", 32'(count), 2);
      chk("lifo_first", out_data, 32'h1111_2222 ^ 32'hFFFF_0000 ^ M);
      step();
      chk("lifo_hold", out_data, 32'h1111_2222 ^ 32'hFFFF_0000 ^ M);
      chk("lifo_hold_valid", 32'(out_valid), 1);
      exp_q.push_back(32'h1111_2222 ^ 32'hFFFF_0000 ^ M);
      exp_q.push_back(32'h5555_6666 ^ 32'hFFFF_0000 ^ M);
      exp_q.push_back(32'h3333_4444 ^ 32'hFFFF_0000 ^ M);
      out_ready = 1'b1;
      wait_idle("lifo");
      chk("lifo_mode_err", 32'(mode_err), 0);
      $display("lifo stream done");

      // Fill to full, overflow, clear, then push+pop while full
      mode_i = 1'b0; key_i = '0; out_ready = 1'b0;
      step();
      for (int i = 0; i < 17; i++) begin
         exp_q.push_back((32'h100 + 32'(i)) ^ M);
         push(32'h100 + 32'(i));
      end
      chk("fill_count", 32'(count), 16);
      chk("fill_full", 32'(full), 1);
      chk("fill_high_th", 32'(high_th), 1);
      chk("fill_low_th", 32'(low_th), 0);
      chk("fill_ovf", 32'(ovf), 0);
      push(32'hDEAD_BEEF);
      chk("ovf_set", 32'(ovf), 1);
      chk("ovf_count", 32'(count), 16);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("ovf_clr", 32'(ovf), 0);
      exp_q.push_back(32'h200 ^ M);
      out_ready = 1'b1; wr_en = 1'b1; wr_data = 32'h200;
      step();
      wr_en = 1'b0; out_ready = 1'b0;
      chk("full_pp_count", 32'(count), 16);
      chk("full_pp_ovf", 32'(ovf), 0);
      out_ready = 1'b1;
      wait_idle("full");
      $display("fill/overflow done");

      // Mode toggle in RUN, then new mode latched after drain
      out_ready = 1'b0; mode_i = 1'b0;
      step();
      exp_q.push_back(32'hA0 ^ M);
      exp_q.push_back(32'hA1 ^ M);
      exp_q.push_back(32'hA2 ^ M);
      push(32'hA0); push(32'hA1); push(32'hA2);
      mode_i = 1'b1;
      step();
      chk("mode_err_set", 32'(mode_err), 1);
      out_ready = 1'b1;
      wait_idle("mode_fifo");
      out_ready = 1'b0;
      exp_q.push_back(32'hB0 ^ M);
      exp_q.push_back(32'hB2 ^ M);
      exp_q.push_back(32'hB1 ^ M);
      push(32'hB0); push(32'hB1); push(32'hB2);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("mode_err_clr", 32'(mode_err), 0);
      out_ready = 1'b1;
      wait_idle("mode_lifo");
      $display("mode toggle done");

      // Reset mid-operation
      out_ready = 1'b0; mode_i = 1'b0;
      step();
      for (int i = 0; i < 6; i++) push(32'hC0 + 32'(i));
      mode_i = 1'b1;
      step();
      chk("pre_rst_count", 32'(count), 5);
      chk("pre_rst_valid", 32'(out_valid), 1);
      chk("pre_rst_mode_err", 32'(mode_err), 1);
      srst = 1'b1;
      step();
      srst = 1'b0;
      chk("mid_rst_count", 32'(count), 0);
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_data", out_data, 0);
      chk("mid_rst_mode_err", 32'(mode_err), 0);
      chk("mid_rst_ovf", 32'(ovf), 0);
      chk("mid_rst_empty", 32'(empty), 1);
      $display("mid-run reset done");

      chk("scoreboard_left", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
